// File: rtl/alu_multicycle.sv
// alu_multicycle: N-bit ALU with a valid/ready handshake on both sides.
// Single-cycle operations resolve in EXEC; multiply runs an iterative
// shift-add loop in MUL, one multiplier bit per cycle. The result and
// flags are held in DONE until the consumer takes them.
module alu_multicycle #(
    parameter int N = 64
) (
    input  logic         input_clk,
    input  logic         input_reset,
    input  logic         input_valid,
    output logic         output_ready,
    input  logic [N-1:0] input_data_1,
    input  logic [N-1:0] input_data_2,
    input  logic [3:0]   input_opcode,
    output logic         output_valid,
    input  logic         input_ready,
    output logic [N-1:0] output_data,
    output logic         output_zero,
    output logic         output_carry,
    output logic         output_overflow,
    output logic         output_error
);

    // Shift amounts use only the low log2(N) bits of B; the multiply
    // counter needs one extra bit so it can reach N.
    localparam int SHW = $clog2(N);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg;

    // Operands captured at accept; later input changes have no effect.
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [3:0]      op_reg;

    // Shift-add multiplier state.
    logic [N-1:0]    mcand_reg;
    logic [N-1:0]    mplier_reg;
    logic [N-1:0]    acc_reg;
    logic [CW-1:0]   cnt_reg;

    // Registered result and handshake outputs.
    logic [N-1:0]    data_reg;
    logic            zero_reg;
    logic            carry_reg;
    logic            ovf_reg;
    logic            err_reg;
    logic            valid_reg;
    logic            ready_reg;

    // Combinational single-cycle datapath.
    logic [N-1:0]    and_bits;
    logic [N-1:0]    or_bits;
    logic [N-1:0]    nor_bits;
    logic [N:0]      sum_ext;
    logic [N-1:0]    diff;
    logic [SHW-1:0]  sh_amt;
    logic [N-1:0]    exec_res;
    logic            exec_carry;
    logic            exec_ovf;
    logic            exec_err;
    logic [N-1:0]    acc_next;

    // Per-bit logic unit shared by AND, OR and NOR.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_logic_unit
            assign and_bits[gi] = a_reg[gi] & b_reg[gi];
            assign or_bits[gi]  = a_reg[gi] | b_reg[gi];
            assign nor_bits[gi] = ~(a_reg[gi] | b_reg[gi]);
        end
    endgenerate

    assign sum_ext = {1'b0, a_reg} + {1'b0, b_reg};
    assign diff    = a_reg - b_reg;
    assign sh_amt  = b_reg[SHW-1:0];

    // Select the single-cycle result and its flags from the latched opcode.
    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_ovf   = 1'b0;
        exec_err   = 1'b0;
        case (op_reg)
            OP_ADD: begin
                exec_res   = sum_ext[N-1:0];
                exec_carry = sum_ext[N];
                exec_ovf   = (a_reg[N-1] == b_reg[N-1]) && (sum_ext[N-1] != a_reg[N-1]);
            end
            OP_SUB: begin
                exec_res   = diff;
                // Carry on subtract means "no borrow".
                exec_carry = (a_reg >= b_reg);
                exec_ovf   = (a_reg[N-1] != b_reg[N-1]) && (diff[N-1] != a_reg[N-1]);
            end
            OP_AND:  exec_res = and_bits;
            OP_OR:   exec_res = or_bits;
            OP_PASS: exec_res = b_reg;
            OP_NOR:  exec_res = nor_bits;
            OP_SLL:  exec_res = a_reg << sh_amt;
            OP_SRL:  exec_res = a_reg >> sh_amt;
            OP_SRA:  exec_res = $unsigned($signed(a_reg) >>> sh_amt);
            OP_SLT:  exec_res = {{(N-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            OP_SLTU: exec_res = {{(N-1){1'b0}}, (a_reg < b_reg)};
            default: begin
                // Undefined opcodes (multiply never reaches EXEC) give 0 + error.
                exec_res = '0;
                exec_err = 1'b1;
            end
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            data_reg   <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (input_valid) begin
                        a_reg     <= input_data_1;
                        b_reg     <= input_data_2;
                        op_reg    <= input_opcode;
                        ready_reg <= 1'b0;
                        if (input_opcode == OP_MUL) begin
                            mcand_reg  <= input_data_1;
                            mplier_reg <= input_data_2;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= MUL;
                        end else begin
                            state_reg  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    data_reg  <= exec_res;
                    zero_reg  <= (exec_res == '0);
                    carry_reg <= exec_carry;
                    ovf_reg   <= exec_ovf;
                    err_reg   <= exec_err;
                    valid_reg <= 1'b1;
                    state_reg <= DONE;
                end
                MUL: begin
                    // N iterations, then one more edge to publish the product.
                    if (cnt_reg == CW'(N)) begin
                        data_reg  <= acc_reg;
                        zero_reg  <= (acc_reg == '0);
                        carry_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                        err_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    // Result stays frozen until taken; no accept on the same edge.
                    if (input_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign output_ready    = ready_reg;
    assign output_valid    = valid_reg;
    assign output_data     = data_reg;
    assign output_zero     = zero_reg;
    assign output_carry    = carry_reg;
    assign output_overflow = ovf_reg;
    assign output_error    = err_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table-driven vectors through a scoreboard queue, plus
// hand-written sequences for result hold, reset priority and reset mid-multiply.
module tb_alu_multicycle;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         in_ready;
    logic [N-1:0] data;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         err;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        z;
        logic        c;
        logic        o;
        logic        e;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        exp_t        want;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    alu_multicycle #(.N(N)) dut (
        .input_clk       (clk),
        .input_reset     (rst),
        .input_valid     (in_valid),
        .output_ready    (out_ready),
        .input_data_1    (a),
        .input_data_2    (b),
        .input_opcode    (op),
        .output_valid    (out_valid),
        .input_ready     (in_ready),
        .output_data     (data),
        .output_zero     (zero),
        .output_carry    (carry),
        .output_overflow (ovf),
        .output_error    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [3:0] vop, input logic [63:0] va, input logic [63:0] vb,
                           input logic [63:0] vd, input logic vz, input logic vc,
                           input logic vo, input logic ve, input int vlat);
        vec_t v;
        v.op     = vop;
        v.a      = va;
        v.b      = vb;
        v.want.d = vd;
        v.want.z = vz;
        v.want.c = vc;
        v.want.o = vo;
        v.want.e = ve;
        v.lat    = vlat;
        vecs.push_back(v);
    endtask

    // Offer one operation, measure latency, compare result, optionally hold it.
    task automatic run_op(input vec_t v, input int idx, input int hold);
        exp_t        w;
        int          lat = 0;
        bit          seen = 0;
        bit          busy_ok = 1;
        bit          got_ready = 0;
        bit          stray = 0;
        logic [63:0] held;
        string       tag;
        tag = $sformatf("v%0d op=%b", idx, v.op);
        for (int t = 0; t < 100; t++) begin
            if (out_ready) begin
                got_ready = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " ready before accept"}, 64'(got_ready), 64'd1);
        if (!got_ready) return;
        op = v.op;
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        sb.push_back(v.want);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 4'($urandom_range(0, 15));
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                seen = 1;
                break;
            end
            if (out_ready) busy_ok = 0;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL %s timeout: no output_valid within 200 cycles, expected after %0d", tag, v.lat);
            void'(sb.pop_front());
            return;
        end
        w = sb.pop_front();
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " ready low while busy"}, 64'(busy_ok & ~out_ready), 64'd1);
        check({tag, " data"}, data, w.d);
        check({tag, " zero"}, 64'(zero), 64'(w.z));
        check({tag, " carry"}, 64'(carry), 64'(w.c));
        check({tag, " overflow"}, 64'(ovf), 64'(w.o));
        check({tag, " error"}, 64'(err), 64'(w.e));
        held = data;
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            a = {$urandom, $urandom};
            op = 4'b0010;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s hold%0d data", tag, h), data, held);
            check($sformatf("%s hold%0d flags", tag, h), {60'd0, zero, carry, ovf, err},
                  {60'd0, w.z, w.c, w.o, w.e});
            check($sformatf("%s hold%0d valid", tag, h), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_ready = 1'b0;
        check({tag, " valid after take"}, 64'(out_valid), 64'd0);
        check({tag, " ready after take"}, 64'(out_ready), 64'd1);
        if (hold > 0) begin
            repeat (4) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid) stray = 1;
            end
            check({tag, " no result from pulses during hold"}, 64'(stray), 64'd0);
        end
        $display("op %b a=%h b=%h -> data=%h z=%b c=%b o=%b e=%b lat=%0d",
                 v.op, v.a, v.b, w.d, w.z, w.c, w.o, w.e, lat);
    endtask

    initial begin
        vec_t tmp;
        bit   stray;

        // op, A, B, data, zero, carry, overflow, error, latency
        add_vec(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 1, 0, 0, 1);
        add_vec(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 0, 1, 0, 1);
        add_vec(4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 1);
        add_vec(4'b0110, 64'd5, 64'd3, 64'd2, 0, 1, 0, 0, 1);
        add_vec(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 1);
        add_vec(4'b0000, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F00_0F00_0F00_0F00, 0, 0, 0, 0, 1);
        add_vec(4'b0001, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFF0F_FF0F_FF0F_FF0F, 0, 0, 0, 0, 1);
        add_vec(4'b0111, 64'd1234, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 1);
        add_vec(4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1);
        add_vec(4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1, 0, 0, 0, 1);
        add_vec(4'b1000, 64'd1, 64'hFFFF_0000_0000_00C5, 64'h20, 0, 0, 0, 0, 1);
        add_vec(4'b1010, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 0, 0, 0, 0, 1);
        add_vec(4'b1001, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 0, 0, 0, 0, 1);
        add_vec(4'b1010, 64'h7000_0000_0000_0000, 64'h44, 64'h0700_0000_0000_0000, 0, 0, 0, 0, 1);
        add_vec(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 0, 0, 0, 1);
        add_vec(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 0, 0, 1);
        add_vec(4'b0011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 0, 0, 1);
        add_vec(4'b0100, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 1);
        add_vec(4'b0101, 64'd5, 64'd7, 64'd0, 1, 0, 0, 1, 1);
        add_vec(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 0, 1, 1);
        add_vec(4'b1110, 64'd123456789, 64'd987654321, 64'd121932631112635269, 0, 0, 0, 0, 65);
        add_vec(4'b1110, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 65);
        add_vec(4'b1110, 64'd0, 64'h1234_5678, 64'd0, 1, 0, 0, 0, 65);

        rst = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 64'(out_ready), 64'd1);
        check("reset valid", 64'(out_valid), 64'd0);
        check("reset data", data, 64'd0);
        check("reset flags", {60'd0, zero, carry, ovf, err}, 64'd0);
        $display("reset: ready=%b valid=%b data=%h", out_ready, out_valid, data);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], i, 0);
        end

        // Hold a result for 10 cycles while input_valid pulses.
        run_op(vecs[1], 100, 10);

        // Reset wins over an accept offered in the same cycle.
        op = 4'b0010;
        a = 64'd9;
        b = 64'd9;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("reset vs accept ready", 64'(out_ready), 64'd1);
        stray = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stray = 1;
        end
        check("reset vs accept no result", 64'(stray), 64'd0);
        $display("reset with concurrent accept: ready=%b stray=%b", out_ready, stray);

        // Reset 20 cycles into a multiply, together with accept and take.
        tmp = vecs[20];
        op = tmp.op;
        a = tmp.a;
        b = tmp.b;
        in_valid = 1'b1;
        sb.push_back(tmp.want);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid-mul ready low", 64'(out_ready), 64'd0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_ready = 1'b1;
        op = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        void'(sb.pop_back());
        check("mul abort valid", 64'(out_valid), 64'd0);
        check("mul abort ready", 64'(out_ready), 64'd1);
        check("mul abort data", data, 64'd0);
        check("mul abort flags", {60'd0, zero, carry, ovf, err}, 64'd0);
        stray = 0;
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stray = 1;
        end
        check("aborted mul never presented", 64'(stray), 64'd0);
        $display("mul aborted by reset: valid=%b ready=%b stray=%b", out_valid, out_ready, stray);

        tmp.op = 4'b0010;
        tmp.a = 64'd2;
        tmp.b = 64'd2;
        tmp.want.d = 64'd4;
        tmp.want.z = 1'b0;
        tmp.want.c = 1'b0;
        tmp.want.o = 1'b0;
        tmp.want.e = 1'b0;
        tmp.lat = 1;
        run_op(tmp, 200, 0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter: N, 64, operand/result width (power of two, 8..64).
REQ-002 SHALL have ports: input_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: input_reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: input_valid  in  1  operation offered.
REQ-005 SHALL have ports: output_ready  out  1  block can accept an operation.
REQ-006 SHALL have ports: input_data_1, input_data_2  in  N  operands A, B.
REQ-007 SHALL have ports: input_opcode  in  4  operation select.
REQ-008 SHALL have ports: output_valid  out  1  result available.
REQ-009 SHALL have ports: input_ready  in  1  consumer takes result.
REQ-010 SHALL have ports: output_data  out  N  result.
REQ-011 SHALL have ports: output_zero, output_carry, output_overflow, output_error  out  1 each  result flags.

Function
REQ-012 SHALL accept an operation on a rising edge where input_valid and output_ready are both 1; operands and opcode latched then, later input changes ignored until next accept.
REQ-013 SHALL implement FSM IDLE -> (EXEC for single-cycle ops | MUL for 1110) -> DONE -> IDLE; output_ready = 1 only in IDLE.
REQ-014 SHALL support opcodes: 0010 A+B, 0110 A-B, 0000 A&B, 0001 A|B, 0111 B, 1100 ~(A|B), 1000 A<<B[log2N-1:0], 1001 logical A>>sh, 1010 arithmetic A>>>sh, 0011 signed A<B ? 1:0, 0100 unsigned A<B ? 1:0, 1110 low N bits of A*B.
REQ-015 SHALL compute single-cycle ops in EXEC: accept at edge k -> output_valid = 1 after edge k+1.
REQ-016 SHALL compute MUL by iterative shift-add, one multiplier bit per cycle, with a log2(N)+1-bit counter: accept at edge k -> output_valid = 1 after edge k+N+1.
REQ-017 SHALL hold output_data and all flags stable in DONE while output_valid = 1 and input_ready = 0.
REQ-018 SHALL leave DONE on the edge where input_ready = 1, entering IDLE (output_valid = 0, output_ready = 1 next cycle); no accept in the same edge.
REQ-019 SHALL set output_zero = (output_data == 0), registered with result.
REQ-020 SHALL set output_carry = carry-out for add, = 1 when no borrow (A >= B unsigned) for sub, else 0.
REQ-021 SHALL set output_overflow = signed two's-complement overflow for add/sub, else 0.
REQ-022 SHALL, for undefined opcodes, complete in EXEC latency with output_data = 0, output_zero = 1, output_error = 1; output_error = 0 for defined opcodes.
REQ-023 SHALL mask shift amount to low log2(N) bits of B; upper bits of B ignored.
REQ-024 SHALL ignore input_valid while output_ready = 0 (no queuing, no error).

Reset
REQ-025 SHALL, while input_reset = 1 at a rising edge, enter IDLE and clear output_data, all flags, output_valid, counter; output_ready = 1 after reset edge.
REQ-026 SHALL abort any in-flight operation (including MUL mid-iteration) on reset; no result ever presented for it.
REQ-027 SHALL give reset priority over accept and over input_ready in the same cycle.

Verification (N = 64)
REQ-028 SHALL pass: add A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> one cycle later output_data=0, zero=1, carry=1, overflow=0.
REQ-029 SHALL pass: add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> output_data=0x8000_0000_0000_0000, overflow=1, carry=0; sub A=3,B=5 -> 0xFFFF_FFFF_FFFF_FFFE, carry=0.
REQ-030 SHALL pass: sra A=0x8000_0000_0000_0000, B=0x43 -> 0xF000_0000_0000_0000 (shift 3); srl same -> 0x1000_0000_0000_0000; slt A=-1,B=1 -> 1, sltu -> 0.
REQ-031 SHALL pass: mul A=123456789, B=987654321 -> 121932631112635269 with output_valid rising exactly 65 edges after accept; output_ready = 0 throughout.
REQ-032 SHALL pass: result held with input_ready=0 for 10 cycles -> data/flags unchanged; input_valid pulses during that time not accepted.
REQ-033 SHALL pass: reset asserted 20 cycles into MUL -> next cycle output_valid=0, output_ready=1, output_data=0; subsequent add 2+2 -> 4.
